coder_arbiter: RTL

Shares the single `coder` serialiser between up to `N_REQ` payload sources (one `payload_generator` per RS-485 channel). It sits between the generators and `coder` on the 24 MHz `clk_en` domain. Access is granted round-robin, one whole frame at a time: a source keeps the coder until it writes a byte flagged `last`. A watchdog reclaims the grant from a source that stalls mid-frame.

---
 rtl/hsi_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/coder_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hsi_pkg.sv
// rtl/hsi_pkg.sv - shared types and widths for the coder arbitration path
package hsi_pkg;

   // Byte width shared by coder, payload_generator and coder_arbiter
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    idx,
   output logic             any
);

   int pos;

   // Scan from the farthest offset back to ptr so the nearest set index wins
   always_comb begin
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         if (req[pos]) begin
            idx = IW'(pos);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coder_arbiter.sv
// rtl/coder_arbiter.sv - round-robin, frame-granular sharing of the coder serialiser
module coder_arbiter #(
   parameter  int N_REQ   = 4,
   parameter  int DATA_W  = hsi_pkg::DATA_W,
   parameter  int TIMEOUT = 255,
   localparam int IW      = $clog2(N_REQ),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clk_en,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        last,
   input  logic [N_REQ*DATA_W-1:0] d,
   output logic [N_REQ-1:0]        busy,
   input  logic                    cd_busy,
   output logic [DATA_W-1:0]       cd_d,
   output logic                    cd_wr_en,
   output logic [IW-1:0]           owner,
   output logic                    active,
   output logic                    err
);

   import hsi_pkg::*;

   arb_state_t        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic              active_q, active_d;
   logic              wr_q, wr_d;
   logic              lst_q, lst_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] cdd_q, cdd_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic [IW-1:0]     owner_nxt;
   logic              xfer;
   logic [DATA_W-1:0] owner_byte;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Explicit wrap so non-power-of-2 N_REQ never lands on an unused index
   assign owner_nxt  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign xfer       = (state_q == GRANT) && req[owner_q] && !cd_busy;
   assign owner_byte = d[int'(owner_q)*DATA_W +: DATA_W];

   // State register: everything freezes while clk_en is low
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         active_q <= 1'b0;
         wr_q     <= 1'b0;
         lst_q    <= 1'b0;
         err_q    <= 1'b0;
         cdd_q    <= '0;
         cnt_q    <= '0;
      end else if (clk_en) begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         active_q <= active_d;
         wr_q     <= wr_d;
         lst_q    <= lst_d;
         err_q    <= err_d;
         cdd_q    <= cdd_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state: grant, byte hand-off, coder handshake and watchdog revocation
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      active_d = active_q;
      wr_d     = 1'b0;
      lst_d    = lst_q;
      err_d    = 1'b0;
      cdd_d    = cdd_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               owner_d  = pick_idx;
               active_d = 1'b1;
               cnt_d    = '0;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               cdd_d   = owner_byte;
               wr_d    = 1'b1;
               lst_d   = last[owner_q];
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end else if (!req[owner_q]) begin
               // The TIMEOUT-th idle cycle revokes; the count never passes TIMEOUT-1
               if (cnt_q >= CW'(TIMEOUT - 1)) begin
                  err_d    = 1'b1;
                  active_d = 1'b0;
                  ptr_d    = owner_nxt;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         WAIT_ACK: begin
            // Coder raises busy during this cycle, so it is not looked at
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!cd_busy) begin
               if (lst_q) begin
                  active_d = 1'b0;
                  ptr_d    = owner_nxt;
                  state_d  = IDLE;
               end else begin
                  state_d = GRANT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: only the owner sees busy low, and only while the coder can accept
   always_comb begin
      busy = '1;
      if ((state_q == GRANT) && !cd_busy) begin
         busy[owner_q] = 1'b0;
      end
   end

   assign cd_d     = cdd_q;
   assign cd_wr_en = wr_q;
   assign owner    = owner_q;
   assign active   = active_q;
   assign err      = err_q;

endmodule
